// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin arbiter driving the select of a registered N-to-1 mux
module rr_sel_arbiter #(
    parameter int N               = 4,
    parameter int ENABLE_STALLING = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 stall,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] sel,
    output logic                 valid,
    output logic                 out_valid
);

    localparam int   PW       = $clog2(N);
    localparam logic STALL_EN = (ENABLE_STALLING != 0);

    logic          hold;
    logic [N-1:0]  elig;
    logic [PW-1:0] ptr;
    logic [PW-1:0] hi_win;
    logic [PW-1:0] lo_win;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;
    logic          hi_found;
    logic          lo_found;

    assign hold = stall & STALL_EN;
    // The source shown this cycle is being consumed, so it sits out one pick.
    assign elig = req & ~grant;

    // Lowest eligible index at or above ptr wins; otherwise the lowest eligible index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_found = 1'b1;
                lo_win   = PW'(i);
                if (PW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_win   = PW'(i);
                end
            end
        end
        win     = hi_found ? hi_win : lo_win;
        ptr_nxt = (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= '0;
            sel       <= '0;
            valid     <= 1'b0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (!hold) begin
            out_valid <= valid;
            if (lo_found) begin
                grant <= N'(1) << win;
                sel   <= win;
                valid <= 1'b1;
                ptr   <= ptr_nxt;
            end else begin
                grant <= '0;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - randomized self-checking bench for rr_sel_arbiter
module tb_rr_sel_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic [3:0] req_a, req_c, grant_a, grant_c;
    logic [2:0] req_b, grant_b;
    logic       stall_a, stall_b, stall_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic       valid_a, valid_b, valid_c;
    logic       ov_a, ov_b, ov_c;

    int n_tests = 0;
    int n_fail  = 0;

    rr_sel_arbiter #(.N(4), .ENABLE_STALLING(1)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .stall(stall_a),
        .grant(grant_a), .sel(sel_a), .valid(valid_a), .out_valid(ov_a));
    rr_sel_arbiter #(.N(3), .ENABLE_STALLING(1)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .stall(stall_b),
        .grant(grant_b), .sel(sel_b), .valid(valid_b), .out_valid(ov_b));
    rr_sel_arbiter #(.N(4), .ENABLE_STALLING(0)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .stall(stall_c),
        .grant(grant_c), .sel(sel_c), .valid(valid_c), .out_valid(ov_c));

    // Reference: granted index (-1 = none), last select, valid, delayed valid, search start.
    typedef struct {
        int gidx;
        int sel;
        bit valid;
        bit ov;
        int ptr;
    } mstate_t;

    mstate_t m_a, m_b, m_c;

    function automatic mstate_t m_reset();
        mstate_t s;
        s.gidx = -1; s.sel = 0; s.valid = 1'b0; s.ov = 1'b0; s.ptr = 0;
        return s;
    endfunction

    function automatic mstate_t m_step(mstate_t s, logic [3:0] r, logic st, int n, bit es);
        mstate_t t = s;
        int      w = -1;
        if (st && es) return s;
        t.ov = s.valid;
        for (int k = 0; k < n; k++) begin
            int c = (s.ptr + k) % n;
            if (w < 0 && r[c[1:0]] && c != s.gidx) w = c;
        end
        if (w >= 0) begin
            t.gidx = w; t.sel = w; t.valid = 1'b1; t.ptr = (w + 1) % n;
        end else begin
            t.gidx = -1; t.valid = 1'b0;
        end
        return t;
    endfunction

    function automatic logic [7:0] m_pack(mstate_t s);
        logic [3:0] g = (s.gidx < 0) ? 4'b0000 : (4'b0001 << s.gidx);
        return {g, 2'(s.sel), s.valid, s.ov};
    endfunction

    function automatic logic [3:0] keep(logic [3:0] r, mstate_t s);
        return (s.gidx < 0) ? r : (r | (4'b0001 << s.gidx));
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_a = m_reset(); m_b = m_reset(); m_c = m_reset();
        end else begin
            m_a = m_step(m_a, req_a, stall_a, 4, 1'b1);
            m_b = m_step(m_b, {1'b0, req_b}, stall_b, 3, 1'b1);
            m_c = m_step(m_c, req_c, stall_c, 4, 1'b0);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;
        #1;
        m_a = m_reset(); m_b = m_reset(); m_c = m_reset();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // Structural invariants on every live cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            n_tests++;
            if (!$onehot0(grant_a) || valid_a !== (|grant_a) || (valid_a && grant_a !== (4'b0001 << sel_a))) begin
                n_fail++;
                $display("FAIL inv_a: grant=%b sel=%0d valid=%b required one-hot grant matching sel/valid", grant_a, sel_a, valid_a);
            end
            n_tests++;
            if (!$onehot0(grant_b) || valid_b !== (|grant_b) || (valid_b && grant_b !== (3'b001 << sel_b)) || sel_b == 2'd3) begin
                n_fail++;
                $display("FAIL inv_b: grant=%b sel=%0d valid=%b required one-hot grant matching sel/valid, sel<3", grant_b, sel_b, valid_b);
            end
            n_tests++;
            if (!$onehot0(grant_c) || valid_c !== (|grant_c) || (valid_c && grant_c !== (4'b0001 << sel_c))) begin
                n_fail++;
                $display("FAIL inv_c: grant=%b sel=%0d valid=%b required one-hot grant matching sel/valid", grant_c, sel_c, valid_c);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        req_a = 4'hf; req_b = 3'h7; req_c = 4'hf;
        stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;
        m_a = m_reset(); m_b = m_reset(); m_c = m_reset();
        repeat (3) begin
            tick();
            n_tests++;
            if ({grant_a, sel_a, valid_a, ov_a} !== 8'h00 || {grant_b, sel_b, valid_b, ov_b} !== 7'h00) begin
                n_fail++;
                $display("FAIL reset_held: a=%b b=%b required all zero", {grant_a, sel_a, valid_a, ov_a}, {grant_b, sel_b, valid_b, ov_b});
            end
        end
        rst = 1'b1;
        #2;
        n_tests++;
        if ({grant_a, sel_a, valid_a, ov_a} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release_pre_edge: got %b required 00000000", {grant_a, sel_a, valid_a, ov_a});
        end
        tick();
        n_tests++;
        if ({grant_a, sel_a, valid_a, ov_a} !== 8'b0001_00_1_0 || {grant_a, sel_a, valid_a, ov_a} !== m_pack(m_a)) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b required %b", {grant_a, sel_a, valid_a, ov_a}, 8'b0001_00_1_0);
        end
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({grant_a, sel_a, valid_a, ov_a} !== 8'h00 || {grant_c, sel_c, valid_c, ov_c} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async_mid: a=%b c=%b required all zero", {grant_a, sel_a, valid_a, ov_a}, {grant_c, sel_c, valid_c, ov_c});
        end
        m_a = m_reset(); m_b = m_reset(); m_c = m_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_rotation();
        do_reset();
        req_a = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if (sel_a !== 2'(k % 4) || valid_a !== 1'b1 || ov_a !== (k >= 1) || {grant_a, sel_a, valid_a, ov_a} !== m_pack(m_a)) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got sel=%0d valid=%b ov=%b required sel=%0d valid=1 ov=%b", k, sel_a, valid_a, ov_a, k % 4, k >= 1);
            end
        end
    endtask

    task automatic test_lone();
        do_reset();
        req_a = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if (grant_a !== ((k % 2 == 0) ? 4'b0100 : 4'b0000) || sel_a !== 2'd2 || {grant_a, sel_a, valid_a, ov_a} !== m_pack(m_a)) begin
                n_fail++;
                $display("FAIL lone[%0d]: got grant=%b sel=%0d required grant=%b sel=2", k, grant_a, sel_a, (k % 2 == 0) ? 4'b0100 : 4'b0000);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] snap;
        do_reset();
        req_a = 4'b0010;
        tick();
        snap = m_pack(m_a);
        n_tests++;
        if ({grant_a, sel_a, valid_a, ov_a} !== 8'b0010_01_1_0) begin
            n_fail++;
            $display("FAIL stall_setup: got %b required 00100110", {grant_a, sel_a, valid_a, ov_a});
        end
        stall_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_a = 4'($urandom);
            tick();
            n_tests++;
            if ({grant_a, sel_a, valid_a, ov_a} !== snap || m_pack(m_a) !== snap) begin
                n_fail++;
                $display("FAIL stall_frozen[%0d]: got %b required %b", k, {grant_a, sel_a, valid_a, ov_a}, snap);
            end
        end
        stall_a = 1'b0;
        req_a = 4'b1111;
        tick();
        n_tests++;
        if (sel_a !== 2'd2 || {grant_a, sel_a, valid_a, ov_a} !== m_pack(m_a)) begin
            n_fail++;
            $display("FAIL stall_resume: got %b required %b", {grant_a, sel_a, valid_a, ov_a}, m_pack(m_a));
        end
    endtask

    task automatic test_wrap_nostall();
        int exp_idx [3] = '{3, 0, 3};
        do_reset();
        req_c = 4'b0100;
        stall_c = 1'b1;
        tick();
        req_c = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            stall_c = 1'b1;
            tick();
            n_tests++;
            if (sel_c !== 2'(exp_idx[k]) || valid_c !== 1'b1 || {grant_c, sel_c, valid_c, ov_c} !== m_pack(m_c)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got sel=%0d valid=%b required sel=%0d valid=1", k, sel_c, valid_c, exp_idx[k]);
            end
        end
        stall_c = 1'b0;
    endtask

    task automatic test_n3();
        do_reset();
        req_b = 3'b111;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_tests++;
            if (sel_b !== 2'(k % 3) || {1'b0, grant_b, sel_b, valid_b, ov_b} !== m_pack(m_b)) begin
                n_fail++;
                $display("FAIL n3[%0d]: got sel=%0d grant=%b required sel=%0d", k, sel_b, grant_b, k % 3);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_a   = keep(4'($urandom), m_a);
            req_b   = 3'(keep({1'b0, 3'($urandom)}, m_b));
            req_c   = keep(4'($urandom), m_c);
            stall_a = ($urandom_range(0, 3) == 0);
            stall_b = ($urandom_range(0, 3) == 0);
            stall_c = ($urandom_range(0, 1) == 0);
            tick();
            n_tests++;
            if ({grant_a, sel_a, valid_a, ov_a} !== m_pack(m_a)) begin
                n_fail++;
                $display("FAIL random_a[%0d]: got %b required %b", k, {grant_a, sel_a, valid_a, ov_a}, m_pack(m_a));
            end
            n_tests++;
            if ({1'b0, grant_b, sel_b, valid_b, ov_b} !== m_pack(m_b)) begin
                n_fail++;
                $display("FAIL random_b[%0d]: got %b required %b", k, {1'b0, grant_b, sel_b, valid_b, ov_b}, m_pack(m_b));
            end
            n_tests++;
            if ({grant_c, sel_c, valid_c, ov_c} !== m_pack(m_c)) begin
                n_fail++;
                $display("FAIL random_c[%0d]: got %b required %b", k, {grant_c, sel_c, valid_c, ov_c}, m_pack(m_c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_lone();
        test_stall();
        test_wrap_nostall();
        test_n3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
